// File: rtl/anemometer_freq_gen.sv
// Programmable square-wave source: an 8-bit Hz value becomes a 50 % duty output via a sequential divider.
// Optional burst mode (fixed number of rising edges, then stop) is enabled by defining FREQ_GEN_BURST_EN.
module anemometer_freq_gen #(
  parameter int CLK_FREQ = 50000000,
  parameter int DATA_W   = 8,
  parameter int CNT_W    = 32
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [DATA_W-1:0] freq_in,
  input  logic              freq_load,
  output logic              busy,
  output logic              freq_out,
  output logic [DATA_W-1:0] cur_freq,
  output logic              rise_pulse
`ifdef FREQ_GEN_BURST_EN
  ,
  input  logic [DATA_W-1:0] burst_len,
  output logic              burst_done
`endif
);

  localparam int BW = $clog2(CNT_W + 1);
  localparam logic [CNT_W-1:0] HALF_CLK = CNT_W'(CLK_FREQ / 2);

  typedef enum logic [1:0] {IDLE, DIV, COMMIT} state_t;

  state_t              state_reg, state_next;
  logic                start, load_zero;
  logic [DATA_W-1:0]   div_f_reg, rem_reg;
  logic [CNT_W-1:0]    quo_reg, dvd_reg;
  logic [BW-1:0]       bit_cnt_reg;
  logic [DATA_W:0]     rem_sh;
  logic [DATA_W-1:0]   rem_diff;
  logic                ge;

  logic [CNT_W-1:0]    pend_reg;
  logic [DATA_W-1:0]   pend_f_reg;
  logic                pend_valid_reg;

  logic [CNT_W-1:0]    half_reg, cnt_reg;
  logic [DATA_W-1:0]   cur_freq_reg;
  logic                out_reg, rise_reg;
  logic                running, toggle, stop_now, adopt, consume, burst_stop;

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    load_zero  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (freq_load && freq_in == '0) begin
          load_zero = 1'b1;
        end else if (freq_load) begin
          start      = 1'b1;
          state_next = DIV;
        end
      end
      DIV:     if (bit_cnt_reg == BW'(CNT_W - 1)) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Restoring division step: remainder stays below the divisor, so DATA_W bits hold it.
  assign rem_sh   = {rem_reg, dvd_reg[CNT_W-1]};
  assign ge       = rem_sh >= {1'b0, div_f_reg};
  assign rem_diff = rem_sh[DATA_W-1:0] - div_f_reg;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_reg   <= IDLE;
      div_f_reg   <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      dvd_reg     <= '0;
      bit_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (start) begin
        div_f_reg   <= freq_in;
        rem_reg     <= '0;
        quo_reg     <= '0;
        dvd_reg     <= HALF_CLK;
        bit_cnt_reg <= '0;
      end else if (state_reg == DIV) begin
        rem_reg     <= ge ? rem_diff : rem_sh[DATA_W-1:0];
        quo_reg     <= {quo_reg[CNT_W-2:0], ge};
        dvd_reg     <= {dvd_reg[CNT_W-2:0], 1'b0};
        bit_cnt_reg <= bit_cnt_reg + BW'(1);
      end
    end
  end

  assign running  = half_reg != '0;
  assign toggle   = running && (cnt_reg == half_reg - CNT_W'(1));
  // A stop while low needs no phase completion, so it preempts any toggle.
  assign stop_now = running && !out_reg && pend_valid_reg && pend_reg == '0;
  assign adopt    = pend_valid_reg && pend_reg != '0 && (!running || (toggle && !burst_stop));
  assign consume  = pend_valid_reg && (!running || stop_now || (toggle && !burst_stop));

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pend_reg       <= '0;
      pend_f_reg     <= '0;
      pend_valid_reg <= 1'b0;
    end else if (state_reg == COMMIT) begin
      pend_reg       <= quo_reg;
      pend_f_reg     <= div_f_reg;
      pend_valid_reg <= 1'b1;
    end else if (load_zero) begin
      pend_reg       <= '0;
      pend_f_reg     <= '0;
      pend_valid_reg <= 1'b1;
    end else if (consume) begin
      pend_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      half_reg     <= '0;
      cnt_reg      <= '0;
      cur_freq_reg <= '0;
      out_reg      <= 1'b0;
      rise_reg     <= 1'b0;
    end else begin
      rise_reg <= 1'b0;
      if (stop_now) begin
        half_reg     <= '0;
        cnt_reg      <= '0;
        cur_freq_reg <= '0;
      end else if (toggle) begin
        cnt_reg  <= '0;
        out_reg  <= ~out_reg;
        rise_reg <= ~out_reg;
        if (burst_stop || (consume && pend_reg == '0)) begin
          half_reg     <= '0;
          cur_freq_reg <= '0;
        end else if (adopt) begin
          half_reg     <= pend_reg;
          cur_freq_reg <= pend_f_reg;
        end
      end else if (adopt) begin
        half_reg     <= pend_reg;
        cur_freq_reg <= pend_f_reg;
        cnt_reg      <= '0;
      end else if (running) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

`ifdef FREQ_GEN_BURST_EN
  logic [DATA_W-1:0] burst_reg, rises_reg;
  logic              done_reg;

  // Burst ends on the falling toggle that follows the final counted rising edge.
  assign burst_stop = toggle && out_reg && burst_reg != '0 && rises_reg == burst_reg;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      burst_reg <= '0;
      rises_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= burst_stop;
      if (adopt) begin
        burst_reg <= burst_len;
        rises_reg <= {{(DATA_W-1){1'b0}}, running && !out_reg};
      end else if (toggle && !out_reg) begin
        rises_reg <= rises_reg + DATA_W'(1);
      end
    end
  end

  assign burst_done = done_reg;
`else
  assign burst_stop = 1'b0;
`endif

  assign busy       = state_reg != IDLE;
  assign freq_out   = out_reg;
  assign cur_freq   = cur_freq_reg;
  assign rise_pulse = rise_reg;

endmodule

// File: tb/tb_anemometer_freq_gen.sv
// Scoreboard bench for anemometer_freq_gen (CLK_FREQ=1000): stimulus queues expected rise events and busy lengths.
module tb_anemometer_freq_gen;

  logic       clk_clk = 1'b0;
  logic       reset_reset_n = 1'b0;
  logic [7:0] freq_in = 8'd0;
  logic       freq_load = 1'b0;
  logic       busy, freq_out, rise_pulse;
  logic [7:0] cur_freq;
`ifdef FREQ_GEN_BURST_EN
  logic [7:0] burst_len = 8'd0;
  logic       burst_done;
`endif

  anemometer_freq_gen #(.CLK_FREQ(1000), .DATA_W(8), .CNT_W(32)) dut (
    .clk_clk(clk_clk),
    .reset_reset_n(reset_reset_n),
    .freq_in(freq_in),
    .freq_load(freq_load),
    .busy(busy),
    .freq_out(freq_out),
    .cur_freq(cur_freq),
    .rise_pulse(rise_pulse)
`ifdef FREQ_GEN_BURST_EN
    ,
    .burst_len(burst_len),
    .burst_done(burst_done)
`endif
  );

  always #5 clk_clk = ~clk_clk;

  typedef struct {int period; int freq;} rise_t;
  rise_t rise_q[$];
  int    busy_q[$];
  int    checks = 0, failures = 0;
  int    cyc = 0, last_rise = 0, busy_len = 0, done_cnt = 0;
  rise_t re;
  int    be;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s = %0d (t=%0t)", name, act, $time);
    end
  endtask

  task automatic push_rise(input int period, input int freq, input int n);
    rise_t r;
    r.period = period;
    r.freq   = freq;
    for (int i = 0; i < n; i++) rise_q.push_back(r);
  endtask

  // Called on a negedge; the strobe covers exactly one rising edge.
  task automatic pulse_load(input logic [7:0] f);
    freq_in   = f;
    freq_load = 1'b1;
    @(negedge clk_clk);
    freq_load = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (rise_q.size() != 0 && n < budget) begin
      @(negedge clk_clk);
      n++;
    end
    if (rise_q.size() != 0) begin
      check("drain_timeout_left", rise_q.size(), 0);
      rise_q.delete();
    end
  endtask

  // Monitor: compares every rise pulse and every completed busy window against the queues.
  always @(posedge clk_clk) begin
    #1;
    cyc++;
    if (!reset_reset_n) begin
      busy_len = 0;
    end else begin
      if (busy) begin
        busy_len++;
      end else if (busy_len != 0) begin
        if (busy_q.size() == 0) check("busy_unexpected", busy_len, 0);
        else begin
          be = busy_q.pop_front();
          check("busy_len", busy_len, be);
        end
        busy_len = 0;
      end
      if (rise_pulse) begin
        check("rise_level", {31'd0, freq_out}, 1);
        if (rise_q.size() == 0) check("rise_unexpected", 1, 0);
        else begin
          re = rise_q.pop_front();
          if (re.period != 0) check("rise_period", cyc - last_rise, re.period);
          check("rise_cur_freq", {24'd0, cur_freq}, re.freq);
        end
        last_rise = cyc;
      end
`ifdef FREQ_GEN_BURST_EN
      if (burst_done) done_cnt++;
`endif
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk_clk);
    check("reset_freq_out", {31'd0, freq_out}, 0);
    check("reset_busy", {31'd0, busy}, 0);
    check("reset_cur_freq", {24'd0, cur_freq}, 0);
    check("reset_rise", {31'd0, rise_pulse}, 0);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);

    // f=5: half 100, period 200
    busy_q.push_back(33);
    push_rise(0, 5, 1);
    push_rise(200, 5, 2);
    pulse_load(8'd5);
    drain(1000);

    // f=250 loaded just after a rise: applied at the falling toggle, then period 4
    busy_q.push_back(33);
    push_rise(102, 250, 1);
    push_rise(4, 250, 2);
    pulse_load(8'd250);
    drain(300);

    // f=3 loaded just after a rise: commit lands before the 9th following rise
    busy_q.push_back(33);
    push_rise(4, 250, 8);
    push_rise(4, 3, 1);
    push_rise(332, 3, 2);
    pulse_load(8'd3);
    drain(1200);

    // f=5, then f=7 while busy must be ignored
    busy_q.push_back(33);
    push_rise(266, 5, 1);
    push_rise(200, 5, 1);
    pulse_load(8'd5);
    repeat (4) @(negedge clk_clk);
    check("busy_during_second_load", {31'd0, busy}, 1);
    pulse_load(8'd7);
    drain(800);

    // stop while high: finish the high phase, then stay low
    pulse_load(8'd0);
    repeat (40) @(negedge clk_clk);
    check("stop_still_high", {31'd0, freq_out}, 1);
    check("stop_cur_freq_before", {24'd0, cur_freq}, 5);
    repeat (100) @(negedge clk_clk);
    check("stop_low", {31'd0, freq_out}, 0);
    check("stop_cur_freq", {24'd0, cur_freq}, 0);
    check("stop_busy", {31'd0, busy}, 0);
    repeat (400) @(negedge clk_clk);
    check("stop_stays_low", {31'd0, freq_out}, 0);

    // reset mid-period and mid-division
    busy_q.push_back(33);
    push_rise(0, 5, 1);
    pulse_load(8'd5);
    drain(400);
    repeat (10) @(negedge clk_clk);
    pulse_load(8'd250);
    repeat (5) @(negedge clk_clk);
    check("pre_reset_busy", {31'd0, busy}, 1);
    check("pre_reset_out", {31'd0, freq_out}, 1);
    #2 reset_reset_n = 1'b0;
    #1;
    check("async_reset_out", {31'd0, freq_out}, 0);
    check("async_reset_busy", {31'd0, busy}, 0);
    check("async_reset_cur_freq", {24'd0, cur_freq}, 0);
    check("async_reset_rise", {31'd0, rise_pulse}, 0);
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    repeat (300) @(negedge clk_clk);
    check("post_reset_out", {31'd0, freq_out}, 0);
    check("post_reset_cur_freq", {24'd0, cur_freq}, 0);

`ifdef FREQ_GEN_BURST_EN
    // burst of 3 rising edges at f=5
    burst_len = 8'd3;
    done_cnt  = 0;
    busy_q.push_back(33);
    push_rise(0, 5, 1);
    push_rise(200, 5, 2);
    pulse_load(8'd5);
    drain(1000);
    repeat (400) @(negedge clk_clk);
    check("burst_done_count", done_cnt, 1);
    check("burst_out_low", {31'd0, freq_out}, 0);
    check("burst_cur_freq", {24'd0, cur_freq}, 0);
`endif

    check("busy_queue_empty", busy_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
